xsip_telemetry_pcie_framer: RTL
===============================

# xsip_telemetry_pcie_framer

Downstream stage of the XSIP telemetry aggregator. It takes each 512-bit PCIe vendor-message snapshot and frames it as a header beat plus eight 64-bit payload beats on an AXI4-Stream-style master port toward the PCIe vendor-message TX path. A two-entry message buffer absorbs a new snapshot while a frame is in flight. Drops, sequence numbering and overflow signalling are handled in-block.

## Interface

- VENDOR_ID, 16'hA1C0: vendor identifier placed in header bits [31:16].
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- msg_in  in  512  telemetry snapshot from the aggregator.
- msg_valid  in  1  single-cycle qualifier for msg_in. No ready is returned.
- m_tdata  out  64  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready from the PCIe TX.
- m_tlast  out  1  high on payload beat 8.
- seq_num  out  16  count of completed frames; wraps at 16'hFFFF→0.
- drop_count  out  16  count of dropped snapshots; saturates at 16'hFFFF.
- busy  out  1  high when either buffer slot is occupied.

## Operation

- Buffer: ACTIVE slot (frame being sent) and PENDING slot, each holding 512 data bits plus an occupied flag.
- Capture on msg_valid, evaluated against slot state after this cycle's frees:
  - ACTIVE free, or freeing this cycle with PENDING empty: load into ACTIVE.
  - Otherwise, PENDING free or freeing this cycle: load into PENDING.
  - Otherwise: drop. Increment drop_count (saturating) and set ovf_flag.
- FSM states:
  - IDLE: tvalid=0. Go to HDR when ACTIVE is occupied.
  - HDR: present the header. On handshake, go to PAY with beat=0.
  - PAY: present msg[64*beat +: 64] and increment beat on each handshake. Beat 7 asserts tlast.
- On the tlast handshake:
  - Free ACTIVE and increment seq_num.
  - If PENDING is occupied, or a capture lands this cycle, move it to ACTIVE and go to HDR.
  - Otherwise go to IDLE.
- Header layout:
  - [63:48] = 16'h5853.
  - [47:32] = seq_num value at header presentation.
  - [31:16] = VENDOR_ID.
  - [15:8] = 8'd8.
  - [7:0] = {7'b0, ovf_flag}.
- ovf_flag: cleared on header handshake. A drop in the same cycle as that handshake leaves it set.
- AXI rules:
  - m_tdata and m_tlast hold stable while tvalid && !tready.
  - tvalid never deasserts without a handshake.
  - tdata is 0 whenever tvalid=0.

## Timing

- Reset values: m_tdata=0, m_tvalid=0, m_tlast=0, seq_num=0, drop_count=0, busy=0. Both slots empty, ovf_flag=0, FSM in IDLE.
- Latency: msg_valid in cycle N while idle gives a header with tvalid=1 in cycle N+1.
- A full frame is 9 beats, so 9 cycles minimum with tready held high.
- Back-to-back frames have no bubble: the next header appears in the cycle after the tlast handshake.
- busy is registered. It rises the cycle after capture and falls the cycle after the last slot frees.
- Sustained rate is one snapshot per 9 cycles. Any faster is absorbed by PENDING only once, then snapshots drop.
- Reset mid-frame: the stream aborts immediately with tvalid=0 and no tlast. Counters return to 0 and both slots clear.

## Structure

- Package xsip_tlm_pkg holds:
  - XSIP_TLM_MAGIC=16'h5853 and XSIP_TLM_BEATS=8.
  - The FSM state enum (IDLE/HDR/PAY).
  - A packed header struct.
- Sub-module xsip_tlm_msg_buf implements the two-slot buffer. Ports: push/data in, pop, head data, head_valid, full, drop pulse.
- The top level contains the FSM, beat mux, and counters.

## Test plan

- Single frame, msg_in = {8{64'h0123_4567_89AB_CDEF}} XOR beat index, tready=1:
  - Header is 64'h5853_0000_A1C0_0800.
  - Beats 1-8 match the 64-bit lanes.
  - tlast is on beat 9 and seq_num becomes 1.
- Backpressure: hold tready=0 for 5 cycles on the header and for 3 cycles on beat 4.
  - tdata and tlast stay stable.
  - Beat count is still 9.
- Three msg_valid pulses in consecutive cycles:
  - Frames 0 and 1 are sent back-to-back with no gap.
  - The third snapshot is dropped and drop_count=1.
  - Frame 1 header flags are 8'h01, and frame 2 flags (after the next snapshot) are 8'h00.
- msg_valid coincident with the tlast handshake, PENDING empty: the new header appears the next cycle and drop_count stays 0.
- Assert rst_n low during beat 5:
  - All outputs go to 0 asynchronously.
  - After release, a fresh snapshot yields header seq=0.
- Force drop_count to 16'hFFFE, then cause 3 drops: it saturates at 16'hFFFF.

Source files
------------

// File: rtl/xsip_tlm_pkg.sv
// Shared types and constants for the XSIP telemetry PCIe framer.
// Frame = one header beat followed by XSIP_TLM_BEATS payload beats.
package xsip_tlm_pkg;

    localparam int unsigned XSIP_TLM_DATA_W = 64;
    localparam int unsigned XSIP_TLM_BEATS  = 8;
    localparam int unsigned XSIP_TLM_MSG_W  = XSIP_TLM_DATA_W * XSIP_TLM_BEATS;
    localparam int unsigned XSIP_TLM_BEAT_W = $clog2(XSIP_TLM_BEATS);
    localparam int unsigned XSIP_TLM_CNT_W  = 16;

    localparam logic [15:0] XSIP_TLM_MAGIC = 16'h5853;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } xsip_tlm_state_e;

    typedef struct packed {
        logic [15:0] magic;
        logic [15:0] seq;
        logic [15:0] vendor;
        logic [7:0]  beats;
        logic [7:0]  flags;
    } xsip_tlm_hdr_t;

    // Assemble the header beat for a frame.
    function automatic xsip_tlm_hdr_t xsip_tlm_mk_hdr(
        input logic [15:0] seq,
        input logic [15:0] vendor,
        input logic        ovf
    );
        xsip_tlm_hdr_t h;
        h.magic  = XSIP_TLM_MAGIC;
        h.seq    = seq;
        h.vendor = vendor;
        h.beats  = 8'(XSIP_TLM_BEATS);
        h.flags  = {7'b0, ovf};
        return h;
    endfunction

endpackage

// File: rtl/xsip_tlm_msg_buf.sv
// Two-slot snapshot buffer: ACTIVE holds the frame on the wire, PENDING one
// snapshot behind it. Placement decisions see this cycle's pop as already done.
module xsip_tlm_msg_buf
    import xsip_tlm_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_push,
    input  logic [XSIP_TLM_MSG_W-1:0] i_data,
    input  logic                      i_pop,
    output logic [XSIP_TLM_MSG_W-1:0] o_head_data,
    output logic                      o_head_valid,
    output logic                      o_full,
    output logic                      o_drop_c
);

    logic [XSIP_TLM_MSG_W-1:0] r_act_data;
    logic [XSIP_TLM_MSG_W-1:0] r_pend_data;
    logic                      r_act_vld;
    logic                      r_pend_vld;
    logic                      w_to_act;
    logic                      w_to_pend;

    always_comb begin
        w_to_act  = 1'b0;
        w_to_pend = 1'b0;
        o_drop_c  = 1'b0;
        if (i_push) begin
            if (!r_act_vld || (i_pop && !r_pend_vld)) begin
                w_to_act = 1'b1;
            end else if (!r_pend_vld || i_pop) begin
                w_to_pend = 1'b1;
            end else begin
                o_drop_c = 1'b1;
            end
        end
    end

    // On pop the pending snapshot (if any) is promoted into ACTIVE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_data  <= '0;
            r_pend_data <= '0;
            r_act_vld   <= 1'b0;
            r_pend_vld  <= 1'b0;
        end else begin
            if (w_to_act) begin
                r_act_data <= i_data;
                r_act_vld  <= 1'b1;
            end else if (i_pop) begin
                r_act_data <= r_pend_data;
                r_act_vld  <= r_pend_vld;
            end
            if (w_to_pend) begin
                r_pend_data <= i_data;
                r_pend_vld  <= 1'b1;
            end else if (i_pop) begin
                r_pend_vld  <= 1'b0;
            end
        end
    end

    assign o_head_data  = r_act_data;
    assign o_head_valid = r_act_vld;
    assign o_full       = r_act_vld && r_pend_vld;

endmodule

// File: rtl/xsip_telemetry_pcie_framer.sv
// Frames 512-bit telemetry snapshots as header + 8 payload beats on a 64-bit
// AXI4-Stream master, with sequence numbering and drop/overflow accounting.
module xsip_telemetry_pcie_framer
    import xsip_tlm_pkg::*;
#(
    parameter logic [15:0] VENDOR_ID = 16'hA1C0
)
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [XSIP_TLM_MSG_W-1:0]  msg_in,
    input  logic                       msg_valid,
    output logic [XSIP_TLM_DATA_W-1:0] m_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       m_tlast,
    output logic [XSIP_TLM_CNT_W-1:0]  seq_num,
    output logic [XSIP_TLM_CNT_W-1:0]  drop_count,
    output logic                       busy
);

    xsip_tlm_state_e              r_state;
    logic [XSIP_TLM_BEAT_W-1:0]   r_beat;
    logic [XSIP_TLM_DATA_W-1:0]   r_tdata;
    logic                         r_tvalid;
    logic                         r_tlast;
    logic [XSIP_TLM_CNT_W-1:0]    r_seq;
    logic [XSIP_TLM_CNT_W-1:0]    r_drop;
    logic                         r_ovf;
    logic                         r_busy;

    logic                         w_hs;
    logic                         w_pop;
    logic                         w_head_valid;
    logic                         w_full;
    logic                         w_drop;
    logic [XSIP_TLM_MSG_W-1:0]    w_head_data;
    logic [XSIP_TLM_CNT_W-1:0]    w_seq_nxt;
    logic                         w_ovf_nxt;
    logic [XSIP_TLM_BEAT_W-1:0]   w_beat_nxt;
    xsip_tlm_hdr_t                w_hdr;

    xsip_tlm_msg_buf u_msg_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (msg_valid),
        .i_data       (msg_in),
        .i_pop        (w_pop),
        .o_head_data  (w_head_data),
        .o_head_valid (w_head_valid),
        .o_full       (w_full),
        .o_drop_c     (w_drop)
    );

    assign w_hs       = r_tvalid && m_tready;
    assign w_pop      = w_hs && (r_state == PAY) && r_tlast;
    assign w_seq_nxt  = w_pop ? r_seq + XSIP_TLM_CNT_W'(1) : r_seq;
    assign w_ovf_nxt  = w_drop || (r_ovf && !(w_hs && (r_state == HDR)));
    assign w_beat_nxt = r_beat + XSIP_TLM_BEAT_W'(1);
    // Header reflects counter/flag values as seen in the cycle it is first presented.
    assign w_hdr      = xsip_tlm_mk_hdr(w_seq_nxt, VENDOR_ID, w_ovf_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_beat   <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_seq    <= '0;
            r_drop   <= '0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_seq  <= w_seq_nxt;
            r_ovf  <= w_ovf_nxt;
            r_busy <= msg_valid || (w_head_valid && !(w_pop && !w_full));
            if (w_drop && (r_drop != {XSIP_TLM_CNT_W{1'b1}})) begin
                r_drop <= r_drop + XSIP_TLM_CNT_W'(1);
            end
            case (r_state)
                IDLE: begin
                    if (msg_valid || w_head_valid) begin
                        r_state  <= HDR;
                        r_tvalid <= 1'b1;
                        r_tdata  <= w_hdr;
                        r_tlast  <= 1'b0;
                    end
                end
                HDR: begin
                    if (w_hs) begin
                        r_state <= PAY;
                        r_beat  <= '0;
                        r_tdata <= w_head_data[XSIP_TLM_DATA_W-1:0];
                        r_tlast <= 1'b0;
                    end
                end
                PAY: begin
                    if (w_hs) begin
                        if (r_tlast) begin
                            // Chain straight into the next frame when another snapshot is ready.
                            if (w_full || msg_valid) begin
                                r_state <= HDR;
                                r_tdata <= w_hdr;
                                r_tlast <= 1'b0;
                            end else begin
                                r_state  <= IDLE;
                                r_tvalid <= 1'b0;
                                r_tdata  <= '0;
                                r_tlast  <= 1'b0;
                            end
                        end else begin
                            r_beat  <= w_beat_nxt;
                            r_tdata <= w_head_data[XSIP_TLM_DATA_W*int'(w_beat_nxt) +: XSIP_TLM_DATA_W];
                            r_tlast <= (w_beat_nxt == XSIP_TLM_BEAT_W'(XSIP_TLM_BEATS - 1));
                        end
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_tvalid <= 1'b0;
                    r_tdata  <= '0;
                    r_tlast  <= 1'b0;
                end
            endcase
        end
    end

    assign m_tdata    = r_tdata;
    assign m_tvalid   = r_tvalid;
    assign m_tlast    = r_tlast;
    assign seq_num    = r_seq;
    assign drop_count = r_drop;
    assign busy       = r_busy;

endmodule
